// File: rtl/fpro_bus_master.sv
// Initiator side of the FPRO MMIO bus: buffers read/write commands, issues single-cycle
// MMIO accesses and returns one in-order response per command.
// Optional: define FPRO_BM_UNUSED_SLOT_CHK_EN to flag reads that return all ones on rsp_err.
module fpro_bus_master #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rd_data,
    output logic              rsp_err,
    output logic              busy,
    // MMIO bus
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wr_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(CMD_DEPTH));
    assign cmd_ready  = ~fifo_full;
    assign push       = cmd_valid & ~fifo_full;

    assign {head_wr, head_addr, head_wr_data} = fifo_mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic issue_done;
    logic rsp_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = fifo_empty ? StIdle : StIssue;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A pop out of RESP chains straight into the next access for back-to-back issue.
    always_comb begin
        pop        = 1'b0;
        issue_done = 1'b0;
        rsp_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pop = ~fifo_empty;
            end
            StIssue: begin
                issue_done = 1'b1;
            end
            StResp: begin
                rsp_done = rsp_ready;
                pop      = rsp_ready & ~fifo_empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    assign busy = ~fifo_empty | (state_q != StIdle);

    // ------------------------------------------------------------------
    // Registered bus outputs
    // ------------------------------------------------------------------
    logic              mmio_cs_q;
    logic              mmio_wr_q;
    logic              mmio_rd_q;
    logic [ADDR_W-1:0] mmio_addr_q;
    logic [DATA_W-1:0] mmio_wr_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_cs_q      <= 1'b0;
            mmio_wr_q      <= 1'b0;
            mmio_rd_q      <= 1'b0;
            mmio_addr_q    <= '0;
            mmio_wr_data_q <= '0;
        end else if (pop) begin
            mmio_cs_q      <= 1'b1;
            mmio_wr_q      <= head_wr;
            mmio_rd_q      <= ~head_wr;
            mmio_addr_q    <= head_addr;
            mmio_wr_data_q <= head_wr ? head_wr_data : '0;
        end else if (issue_done) begin
            mmio_cs_q      <= 1'b0;
            mmio_wr_q      <= 1'b0;
            mmio_rd_q      <= 1'b0;
            mmio_addr_q    <= '0;
            mmio_wr_data_q <= '0;
        end
    end

    assign mmio_cs      = mmio_cs_q;
    assign mmio_wr      = mmio_wr_q;
    assign mmio_rd      = mmio_rd_q;
    assign mmio_addr    = mmio_addr_q;
    assign mmio_wr_data = mmio_wr_data_q;

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic              rsp_valid_q;
    logic              rsp_wr_q;
    logic [DATA_W-1:0] rsp_rd_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_rd_data_q <= '0;
        end else if (issue_done) begin
            rsp_valid_q   <= 1'b1;
            rsp_wr_q      <= mmio_wr_q;
            rsp_rd_data_q <= mmio_wr_q ? '0 : mmio_rd_data;
        end else if (rsp_done) begin
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_rd_data_q <= '0;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_rd_data = rsp_rd_data_q;

`ifdef FPRO_BM_UNUSED_SLOT_CHK_EN
    // Unused MMIO slots read back as all ones.
    logic rsp_err_q;
    logic unused_slot_hit;

    assign unused_slot_hit = mmio_rd_q & (mmio_rd_data == {DATA_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
        end else if (issue_done) begin
            rsp_err_q <= unused_slot_hit;
        end else if (rsp_done) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpro_bus_master.sv
// Randomized bench for fpro_bus_master against a queue-based transaction model;
// honours FPRO_BM_UNUSED_SLOT_CHK_EN for the rsp_err expectation.
module tb_fpro_bus_master;

    localparam int unsigned CMD_DEPTH = 4;
    localparam int unsigned ADDR_W    = 21;
    localparam int unsigned DATA_W    = 32;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wr_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_wr;
    logic [DATA_W-1:0] rsp_rd_data;
    logic              rsp_err;
    logic              busy;
    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;

    fpro_bus_master #(
        .CMD_DEPTH(CMD_DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wr_data (cmd_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wr      (rsp_wr),
        .rsp_rd_data (rsp_rd_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mmio_cs     (mmio_cs),
        .mmio_wr     (mmio_wr),
        .mmio_rd     (mmio_rd),
        .mmio_addr   (mmio_addr),
        .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory map: a few fixed slots, everything else a hash of the address.
    function automatic logic [DATA_W-1:0] slave_val(input logic [ADDR_W-1:0] a);
        case (a)
            21'h00100: slave_val = 32'h0000_02A5;
            21'h1FFF0: slave_val = 32'hFFFF_FFFF;
            21'h1FFF1: slave_val = 32'hFFFF_FFFE;
            default:   slave_val = {a[10:0], a} ^ 32'hA5C3_0F12;
        endcase
    endfunction

    assign mmio_rd_data = mmio_cs ? slave_val(mmio_addr) : '0;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    int unsigned checks;
    int unsigned errors;

    // Transaction model: queued commands, the one on the bus, the one awaiting rsp_ready.
    cmd_t        mq[$];
    cmd_t        cur;
    bit          m_issue;
    bit          m_rsp;
    bit          m_rsp_wr;
    logic [DATA_W-1:0] m_rsp_data;
    bit          m_rsp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_err_of(input bit wr, input logic [DATA_W-1:0] d);
`ifdef FPRO_BM_UNUSED_SLOT_CHK_EN
        exp_err_of = !wr && (d == {DATA_W{1'b1}});
`else
        exp_err_of = 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_issue = 1'b0;
        m_rsp   = 1'b0;
    endtask

    task automatic compare_all();
        check_eq("cmd_ready", 64'(cmd_ready), 64'(mq.size() < CMD_DEPTH));
        check_eq("busy", 64'(busy), 64'((mq.size() > 0) || m_issue || m_rsp));
        check_eq("mmio_cs", 64'(mmio_cs), 64'(m_issue));
        if (m_issue) begin
            check_eq("mmio_wr", 64'(mmio_wr), 64'(cur.wr));
            check_eq("mmio_rd", 64'(mmio_rd), 64'(!cur.wr));
            check_eq("mmio_addr", 64'(mmio_addr), 64'(cur.addr));
            if (cur.wr) begin
                check_eq("mmio_wr_data", 64'(mmio_wr_data), 64'(cur.data));
            end
        end else begin
            check_eq("mmio_idle", 64'({mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}), 64'(0));
        end
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        check_eq("rsp_err", 64'(rsp_err), 64'(m_rsp && m_rsp_err));
        if (m_rsp) begin
            check_eq("rsp_wr", 64'(rsp_wr), 64'(m_rsp_wr));
            check_eq("rsp_rd_data", 64'(rsp_rd_data), 64'(m_rsp_data));
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit   acc;
        bit   can_pop;
        cmd_t incoming;
        @(posedge clk);
        acc      = cmd_valid && (mq.size() < CMD_DEPTH);
        incoming = '{wr: cmd_wr, addr: cmd_addr, data: cmd_wr_data};
        can_pop  = (!m_issue && !m_rsp) || (m_rsp && rsp_ready);
        if (m_issue) begin
            m_issue    = 1'b0;
            m_rsp      = 1'b1;
            m_rsp_wr   = cur.wr;
            m_rsp_data = cur.wr ? '0 : slave_val(cur.addr);
            m_rsp_err  = exp_err_of(cur.wr, m_rsp_data);
        end else if (can_pop) begin
            m_rsp = 1'b0;
            if (mq.size() > 0) begin
                cur     = mq.pop_front();
                m_issue = 1'b1;
            end
        end
        if (acc) begin
            mq.push_back(incoming);
        end
        #1;
        compare_all();
    endtask

    task automatic drive_cmd(input bit v, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        cmd_valid   = v;
        cmd_wr      = wr;
        cmd_addr    = a;
        cmd_wr_data = d;
    endtask

    task automatic idle_cycles(input int n);
        drive_cmd(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        model_reset();
        reset = 1'b0;
        rsp_ready = 1'b0;
        drive_cmd(1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1 compare_all();

        // Single write, then single read of the 0x2A5 slot.
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 1'b1, 21'h000C0, 32'h0000_03FF);
        step();
        idle_cycles(4);
        drive_cmd(1'b1, 1'b0, 21'h00100, 32'hDEAD_BEEF);
        step();
        idle_cycles(4);

        // Fill with reads under response backpressure, hold, then drain in order.
        rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_cmd(1'b1, 1'b0, ADDR_W'(21'h00200 + i), 32'h0);
            step();
        end
        idle_cycles(10);
        rsp_ready = 1'b1;
        idle_cycles(16);

        // Unused-slot reads: all ones and one-off-all-ones.
        drive_cmd(1'b1, 1'b0, 21'h1FFF0, 32'h0);
        step();
        drive_cmd(1'b1, 1'b0, 21'h1FFF1, 32'h0);
        step();
        idle_cycles(6);

        // Reset in the middle of a bus access.
        drive_cmd(1'b1, 1'b0, 21'h00300, 32'h0);
        step();
        drive_cmd(1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            seen = m_issue;
        end
        check_eq("reach_issue", 64'(mmio_cs), 64'(1));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mmio_cs", 64'(mmio_cs), 64'(0));
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        #1 compare_all();
        idle_cycles(2);

        // Random traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] a;
            case ($urandom_range(0, 7))
                0:       a = 21'h1FFF0;
                1:       a = 21'h1FFF1;
                2:       a = 21'h00100;
                default: a = ADDR_W'($urandom);
            endcase
            drive_cmd($urandom_range(0, 99) < 60, 1'($urandom), a, 32'($urandom));
            rsp_ready = $urandom_range(0, 99) < 70;
            step();
        end
        rsp_ready = 1'b1;
        idle_cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
